// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register file bus: write port, two read ports, issue/scoreboard
// signals and the soft-clear handshake.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              sig_regWrite;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              sig_issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              busy1;
  logic              busy2;
  logic              sig_clear;
  logic              clear_busy;

  modport master (
    output sig_regWrite, wr_addr, wr_data, rd_addr1, rd_addr2,
           sig_issue, issue_addr, sig_clear,
    input  data1, data2, busy1, busy2, clear_busy
  );

  modport slave (
    input  sig_regWrite, wr_addr, wr_data, rd_addr1, rd_addr2,
           sig_issue, issue_addr, sig_clear,
    output data1, data2, busy1, busy2, clear_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-to-read bypass, optional hardwired zero
// register, per-register pending-write scoreboard and a sequential soft clear.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;

  logic idle_s;
  logic wr_keep_s;
  logic byp1_s, byp2_s;
  logic hit1_s, hit2_s;
  logic [DATA_W-1:0] data1_s, data2_s;

  // A write to the hardwired zero register is discarded entirely, including bypass.
  assign idle_s    = (state_q == IDLE);
  assign wr_keep_s = idle_s && bus.sig_regWrite && !(ZR && (bus.wr_addr == ADDR_ZERO));
  assign byp1_s    = wr_keep_s && (bus.wr_addr == bus.rd_addr1);
  assign byp2_s    = wr_keep_s && (bus.wr_addr == bus.rd_addr2);
  assign hit1_s    = idle_s && bus.sig_regWrite && (bus.wr_addr == bus.rd_addr1);
  assign hit2_s    = idle_s && bus.sig_regWrite && (bus.wr_addr == bus.rd_addr2);

  // Read port data mux: zero register, bypass, then storage.
  always_comb begin
    data1_s = regs_q[bus.rd_addr1];
    data2_s = regs_q[bus.rd_addr2];
    if (ZR && (bus.rd_addr1 == ADDR_ZERO)) begin
      data1_s = {DATA_W{1'b0}};
    end else if (byp1_s) begin
      data1_s = bus.wr_data;
    end else begin
      data1_s = regs_q[bus.rd_addr1];
    end
    if (ZR && (bus.rd_addr2 == ADDR_ZERO)) begin
      data2_s = {DATA_W{1'b0}};
    end else if (byp2_s) begin
      data2_s = bus.wr_data;
    end else begin
      data2_s = regs_q[bus.rd_addr2];
    end
  end

  assign bus.data1      = data1_s;
  assign bus.data2      = data2_s;
  assign bus.busy1      = pending_q[bus.rd_addr1] && !hit1_s;
  assign bus.busy2      = pending_q[bus.rd_addr2] && !hit2_s;
  assign bus.clear_busy = (state_q == CLEAR);

  // Next-state logic for storage, scoreboard and the clear sweep.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    regs_d    = regs_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (wr_keep_s) begin
          regs_d[bus.wr_addr] = bus.wr_data;
        end else begin
          regs_d[bus.wr_addr] = regs_q[bus.wr_addr];
        end
        // Clear before set so a same-address issue keeps the register pending.
        if (bus.sig_regWrite) begin
          pending_d[bus.wr_addr] = 1'b0;
        end else begin
          pending_d[bus.wr_addr] = pending_q[bus.wr_addr];
        end
        if (bus.sig_issue && !(ZR && (bus.issue_addr == ADDR_ZERO))) begin
          pending_d[bus.issue_addr] = 1'b1;
        end else begin
          pending_d[bus.issue_addr] = pending_d[bus.issue_addr];
        end
        if (bus.sig_clear) begin
          state_d = CLEAR;
          idx_d   = ADDR_ZERO;
        end else begin
          state_d = IDLE;
          idx_d   = idx_q;
        end
      end
      CLEAR: begin
        regs_d[idx_q]    = {DATA_W{1'b0}};
        pending_d[idx_q] = 1'b0;
        idx_d            = idx_q + ADDR_ONE;
        if (idx_q == ADDR_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = ADDR_ZERO;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= ADDR_ZERO;
      pending_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      regs_q    <= regs_d;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_regfile_scoreboard;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents, pending flags, sweep position (-1 = idle).
  int unsigned m_reg  [DEPTH];
  bit          m_pend [DEPTH];
  int          m_sweep;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = 0;
      m_pend[i] = 1'b0;
    end
    m_sweep = -1;
  endtask

  task automatic model_tick();
    int wa, ia;
    wa = int'(ifc.wr_addr);
    ia = int'(ifc.issue_addr);
    if (m_sweep >= 0) begin
      m_reg[m_sweep]  = 0;
      m_pend[m_sweep] = 1'b0;
      m_sweep = m_sweep + 1;
      if (m_sweep == DEPTH) m_sweep = -1;
    end else begin
      if (ifc.sig_regWrite && wa != 0) m_reg[wa] = int'(ifc.wr_data);
      if (ifc.sig_regWrite) m_pend[wa] = 1'b0;
      if (ifc.sig_issue && ia != 0) m_pend[ia] = 1'b1;
      if (ifc.sig_clear) m_sweep = 0;
    end
  endtask

  function automatic int unsigned exp_data(int a);
    if (a == 0) return 0;
    if (m_sweep < 0 && ifc.sig_regWrite && int'(ifc.wr_addr) == a) return int'(ifc.wr_data);
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(int a);
    if (m_sweep < 0 && ifc.sig_regWrite && int'(ifc.wr_addr) == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_data1"}, 32'(ifc.data1), exp_data(int'(ifc.rd_addr1)));
    chk({tag, "_data2"}, 32'(ifc.data2), exp_data(int'(ifc.rd_addr2)));
    chk({tag, "_busy1"}, 32'(ifc.busy1), 32'(exp_busy(int'(ifc.rd_addr1))));
    chk({tag, "_busy2"}, 32'(ifc.busy2), 32'(exp_busy(int'(ifc.rd_addr2))));
    chk({tag, "_clrbusy"}, 32'(ifc.clear_busy), 32'(m_sweep >= 0));
  endtask

  task automatic step(string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    ifc.sig_regWrite = 1'b0;
    ifc.sig_issue    = 1'b0;
    ifc.sig_clear    = 1'b0;
  endtask

  initial begin
    int cnt;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    idle_inputs();
    ifc.wr_addr = 3'd0; ifc.wr_data = 16'd0; ifc.issue_addr = 3'd0;
    ifc.rd_addr1 = 3'd0; ifc.rd_addr2 = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    ifc.rd_addr1 = 3'd1; ifc.rd_addr2 = 3'd2;
    #1;
    chk("rst_data1", 32'(ifc.data1), 32'd0);
    chk("rst_data2", 32'(ifc.data2), 32'd0);
    chk("rst_busy1", 32'(ifc.busy1), 32'd0);
    chk("rst_busy2", 32'(ifc.busy2), 32'd0);
    chk("rst_clrbusy", 32'(ifc.clear_busy), 32'd0);

    // Write with same-cycle bypass, then read from storage
    ifc.sig_regWrite = 1'b1; ifc.wr_addr = 3'd3; ifc.wr_data = 16'd69; ifc.rd_addr1 = 3'd3;
    #1 chk("bypass_data1", 32'(ifc.data1), 32'd69);
    step("bypass");
    ifc.sig_regWrite = 1'b0;
    #1 chk("stored_data1", 32'(ifc.data1), 32'd69);
    step("stored");

    // Zero register ignores writes and issues
    ifc.sig_regWrite = 1'b1; ifc.wr_addr = 3'd0; ifc.wr_data = 16'hBEEF;
    ifc.sig_issue = 1'b1; ifc.issue_addr = 3'd0; ifc.rd_addr1 = 3'd0;
    #1;
    chk("zero_wr_data1", 32'(ifc.data1), 32'd0);
    chk("zero_wr_busy1", 32'(ifc.busy1), 32'd0);
    step("zero_wr");
    idle_inputs();
    #1;
    chk("zero_after_data1", 32'(ifc.data1), 32'd0);
    chk("zero_after_busy1", 32'(ifc.busy1), 32'd0);
    step("zero_after");

    // Scoreboard set / clear / same-address set-wins
    ifc.sig_issue = 1'b1; ifc.issue_addr = 3'd5; ifc.rd_addr2 = 3'd5;
    step("issue5");
    ifc.sig_issue = 1'b0;
    #1 chk("issue5_busy2", 32'(ifc.busy2), 32'd1);
    ifc.sig_regWrite = 1'b1; ifc.wr_addr = 3'd5; ifc.wr_data = 16'd100;
    #1 chk("write5_busy2", 32'(ifc.busy2), 32'd0);
    step("write5");
    ifc.sig_regWrite = 1'b0;
    #1 chk("after5_busy2", 32'(ifc.busy2), 32'd0);
    chk("after5_data2", 32'(ifc.data2), 32'd100);
    ifc.sig_regWrite = 1'b1; ifc.wr_data = 16'd7; ifc.sig_issue = 1'b1; ifc.issue_addr = 3'd5;
    step("both5");
    idle_inputs();
    #1 chk("both5_busy2", 32'(ifc.busy2), 32'd1);

    // Soft clear sweep with preloaded contents and a dropped write
    for (int i = 1; i < DEPTH; i++) begin
      ifc.sig_regWrite = 1'b1; ifc.wr_addr = 3'(i); ifc.wr_data = 16'(10 * i);
      step("preload");
    end
    ifc.sig_regWrite = 1'b0; ifc.sig_issue = 1'b1; ifc.issue_addr = 3'd7;
    step("preissue");
    ifc.sig_issue = 1'b0; ifc.sig_clear = 1'b1;
    ifc.rd_addr1 = 3'd7; ifc.rd_addr2 = 3'd6;
    step("clr_start");
    ifc.sig_clear = 1'b0;
    cnt = 0;
    while (ifc.clear_busy === 1'b1 && cnt < 20) begin
      cnt++;
      if (cnt == 2) begin
        ifc.sig_regWrite = 1'b1; ifc.wr_addr = 3'd7; ifc.wr_data = 16'd55;
        ifc.sig_issue = 1'b1; ifc.issue_addr = 3'd7; ifc.sig_clear = 1'b1;
        #1 chk("sweep_nobypass", 32'(ifc.data1), 32'd70);
      end else begin
        idle_inputs();
      end
      step("sweep");
    end
    chk("sweep_len", 32'(cnt), 32'd8);
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      ifc.rd_addr1 = 3'(a); ifc.rd_addr2 = 3'(a);
      #1;
      chk("post_clr_data1", 32'(ifc.data1), 32'd0);
      chk("post_clr_busy2", 32'(ifc.busy2), 32'd0);
    end
    step("post_clr");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      ifc.sig_regWrite = 1'($urandom_range(0, 1));
      ifc.wr_addr      = 3'($urandom_range(0, 7));
      ifc.wr_data      = 16'($urandom);
      ifc.sig_issue    = 1'($urandom_range(0, 1));
      ifc.issue_addr   = 3'($urandom_range(0, 7));
      ifc.rd_addr1     = 3'($urandom_range(0, 7));
      ifc.rd_addr2     = ($urandom_range(0, 3) == 0) ? ifc.wr_addr : 3'($urandom_range(0, 7));
      ifc.sig_clear    = ($urandom_range(0, 39) == 0);
      step("rand");
    end
    idle_inputs();
    while (m_sweep >= 0) step("drain");

    // Reset in the third cycle of a sweep
    ifc.sig_regWrite = 1'b1; ifc.wr_addr = 3'd6; ifc.wr_data = 16'h0066;
    step("pre_rst_wr");
    ifc.sig_regWrite = 1'b0; ifc.sig_clear = 1'b1;
    step("rst_clr_start");
    ifc.sig_clear = 1'b0;
    step("rst_sweep1");
    step("rst_sweep2");
    rst = 1'b1;
    #1;
    chk("midrst_clrbusy", 32'(ifc.clear_busy), 32'd0);
    model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      ifc.rd_addr1 = 3'(a);
      #1 chk("midrst_data1", 32'(ifc.data1), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    ifc.sig_regWrite = 1'b1; ifc.wr_addr = 3'd4; ifc.wr_data = 16'h1234; ifc.rd_addr1 = 3'd4;
    step("post_rst_wr");
    ifc.sig_regWrite = 1'b0;
    #1 chk("post_rst_data1", 32'(ifc.data1), 32'h1234);
    step("post_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
